score_ctrl: RTL and testbench

- Game-flow controller for the score path: a run/pause/game-over state machine, a point-rate tick divider and a saturating score counter.
- Keeps a high-score register and arbitrates which value (current or high) drives the score display input.
- Sits between the game logic (start, pause, collision) and the score display block, which consumes score_out on the same clk2.

---
 rtl/score_ctrl.sv | 129 ++++++++++++
 tb/tb_score_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// score_ctrl: run/pause/over FSM, point tick divider, saturating score, high score and display mux; SCORE_BLINK_EN adds new-high blink
module score_ctrl #(
    parameter int SCORE_W   = 10,
    parameter int TICK_DIV  = 25,
    parameter int SCORE_MAX = 999,
    parameter int BLINK_DIV = 8
) (
    input  logic               clk2,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               collide,
    input  logic               show_high,
    output logic [SCORE_W-1:0] score_out,
    output logic [1:0]         state,
    output logic               game_over,
    output logic               new_high
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] SMAX = SCORE_W'(SCORE_MAX);

    if (TICK_DIV < 2) begin : g_bad_tick
        $error("TICK_DIV must be >= 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("BLINK_DIV must be >= 1");
    end

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, OVER = 2'b11} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [SCORE_W-1:0] score_q, score_d, high_q, high_d, out_q, out_d;
    logic               new_high_q, new_high_d, start_q, start_rise, show_sel;

    assign start_rise = start & ~start_q;
    assign show_sel   = (state_q == IDLE || state_q == OVER) && show_high;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        case (state_q)
            IDLE: begin
                tick_d  = '0;
                score_d = '0;
                state_d = start_rise ? RUN : IDLE;
            end
            RUN: begin
                if (collide) begin
                    state_d = OVER;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                    score_d = (tick_q == TICK_LAST && score_q < SMAX) ? score_q + 1'b1 : score_q;
                end
            end
            PAUSE: state_d = pause ? PAUSE : RUN;
            default: begin
                if (start_rise) begin
                    state_d    = RUN;
                    tick_d     = '0;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end
            end
        endcase
    end

`ifdef SCORE_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d, over_entry;

    assign over_entry = state_d == OVER && state_q != OVER;

    always_comb begin
        blink_cnt_d = over_entry ? '0 : (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_off_d = over_entry ? 1'b0 : (state_q == OVER && blink_cnt_q == BLINK_LAST) ? ~blink_off_q : blink_off_q;
        out_d       = show_sel ? high_q : (state_q == OVER && new_high_q && blink_off_q) ? '0 : score_q;
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end
`else
    assign out_d = show_sel ? high_q : score_q;
`endif

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            score_q    <= '0;
            high_q     <= '0;
            out_q      <= '0;
            new_high_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            score_q    <= score_d;
            high_q     <= high_d;
            out_q      <= out_d;
            new_high_q <= new_high_d;
            start_q    <= start;
        end
    end

    assign score_out = out_q;
    assign state     = state_q;
    assign game_over = state_q == OVER;
    assign new_high  = new_high_q;
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed game sequence against a cycle model, expectations queued per step
module tb_score_ctrl;
    localparam int W = 10, TD = 4, SM = 5;

    logic clk2 = 1'b0, reset = 1'b0, start = 1'b0, pause = 1'b0, collide = 1'b0, show_high = 1'b0;
    logic [W-1:0] score_out;
    logic [1:0]   state;
    logic         game_over, new_high;

    always #5 clk2 = ~clk2;

    score_ctrl #(.SCORE_W(W), .TICK_DIV(TD), .SCORE_MAX(SM), .BLINK_DIV(8)) dut (
        .clk2(clk2), .reset(reset), .start(start), .pause(pause), .collide(collide),
        .show_high(show_high), .score_out(score_out), .state(state),
        .game_over(game_over), .new_high(new_high)
    );

    typedef struct {
        logic [1:0]   st;
        logic [W-1:0] so;
        logic         go;
        logic         nh;
    } exp_t;

    exp_t sb[$];
    int errors = 0, checks = 0;
    int m_state = 0, m_score = 0, m_high = 0, m_tick = 0, m_nh = 0, m_sd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic st, input logic pa, input logic co, input logic sh);
        int ns, nsc, nh, nt, nnh, so;
        bit rise;
        exp_t e, g;
        @(negedge clk2);
        start = st; pause = pa; collide = co; show_high = sh;
        rise = st && m_sd == 0;
        so   = ((m_state == 0 || m_state == 3) && sh) ? m_high : m_score;
        ns = m_state; nsc = m_score; nh = m_high; nt = m_tick; nnh = m_nh;
        case (m_state)
            0: begin nsc = 0; nt = 0; if (rise) ns = 1; end
            1: begin
                if (co) begin
                    ns = 3;
                    if (m_score > m_high) begin nh = m_score; nnh = 1; end
                end else if (pa) ns = 2;
                else if (m_tick == TD - 1) begin nt = 0; if (m_score < SM) nsc = m_score + 1; end
                else nt = m_tick + 1;
            end
            2: if (!pa) ns = 1;
            default: if (rise) begin ns = 1; nsc = 0; nt = 0; nnh = 0; end
        endcase
        m_state = ns; m_score = nsc; m_high = nh; m_tick = nt; m_nh = nnh; m_sd = st ? 1 : 0;
        e.st = 2'(ns); e.so = W'(so); e.go = ns == 3; e.nh = nnh != 0;
        sb.push_back(e);
        @(posedge clk2);
        #1;
        g = sb.pop_front();
        chk("state", 32'(state), 32'(g.st));
        chk("score_out", 32'(score_out), 32'(g.so));
        chk("game_over", 32'(game_over), 32'(g.go));
        chk("new_high", 32'(new_high), 32'(g.nh));
    endtask

    task automatic run_until(input int s, input int t, input string tag);
        int n = 0;
        while (!(m_state == 1 && m_score == s && m_tick == t) && n < 200) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk({tag, "_reached"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk2);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_score_out", 32'(score_out), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_new_high", 32'(new_high), 32'd0);
        @(negedge clk2);
        reset = 1'b1;
        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        chk("idle_ignores", 32'(state), 32'd0);
        step(1, 0, 0, 0);
        chk("run_entry", 32'(state), 32'd1);
        step(1, 0, 0, 0);
        run_until(1, 2, "pause_point");
        repeat (10) step(0, 1, 0, 0);
        chk("paused_state", 32'(state), 32'd2);
        chk("paused_score", 32'(score_out), 32'd1);
        step(0, 0, 0, 0);
        chk("resume_state", 32'(state), 32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("resume_no_early", 32'(score_out), 32'd1);
        step(0, 0, 0, 0);
        chk("resume_incr", 32'(score_out), 32'd2);
        run_until(2, 3, "collide_point");
        step(0, 0, 1, 0);
        chk("over_state", 32'(state), 32'd3);
        chk("over_new_high", 32'(new_high), 32'd1);
        chk("over_game_over", 32'(game_over), 32'd1);
        step(0, 0, 0, 1);
        chk("over_show_high", 32'(score_out), 32'd2);
        step(1, 0, 0, 0);
        chk("restart_nh_clr", 32'(new_high), 32'd0);
        run_until(1, 0, "second_game");
        step(0, 0, 1, 0);
        chk("no_new_high", 32'(new_high), 32'd0);
        step(0, 0, 0, 1);
        chk("show_high_kept", 32'(score_out), 32'd2);
        step(0, 0, 0, 0);
        chk("show_current", 32'(score_out), 32'd1);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0);
        chk("held_start_no_retrig", 32'(state), 32'd3);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (40) step(0, 0, 0, 1);
        chk("saturate_score", 32'(score_out), 32'd5);
        chk("saturate_state", 32'(state), 32'd1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("high_now_max", 32'(score_out), 32'd5);
        step(1, 0, 0, 0);
        run_until(3, 0, "reset_point");
        @(negedge clk2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_score_out", 32'(score_out), 32'd0);
        chk("async_rst_new_high", 32'(new_high), 32'd0);
        m_state = 0; m_score = 0; m_high = 0; m_tick = 0; m_nh = 0; m_sd = 0;
        start = 1'b0; pause = 1'b0; collide = 1'b0; show_high = 1'b0;
        @(negedge clk2);
        reset = 1'b1;
        step(0, 0, 0, 1);
        chk("high_cleared", 32'(score_out), 32'd0);
        step(0, 0, 0, 0);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
